// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared sequencer state codes and pc constants
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_REGREAD   = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_BRANCH    = 3'd4,
    ST_MEM       = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_PC_UPDATE = 3'd7
  } seq_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - sequencer handshake and status bundle
interface pc_sequencer_if;

  logic        imem_ready;
  logic        dmem_ready;
  logic        is_load;
  logic        is_store;
  logic        has_rd;
  logic        taken_branch;
  logic [31:0] branch_target;
  logic        halt_req;

  logic [2:0]  state;
  logic [31:0] pc;
  logic        imem_req;
  logic        dmem_req;
  logic        rf_we;
  logic        halted;
  logic        fault;

  modport master (
    input  imem_ready, dmem_ready, is_load, is_store, has_rd,
    input  taken_branch, branch_target, halt_req,
    output state, pc, imem_req, dmem_req, rf_we, halted, fault
  );

  modport slave (
    output imem_ready, dmem_ready, is_load, is_store, has_rd,
    output taken_branch, branch_target, halt_req,
    input  state, pc, imem_req, dmem_req, rf_we, halted, fault
  );

endinterface

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - counts consecutive memory wait cycles
module wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || !waiting) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // High during the LIMIT-th consecutive wait cycle; the caller decides what wins.
  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle instruction sequencer with pc and fault control
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.master bus
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic        waiting;
  logic        expired;
  logic        strobe_en;

  assign waiting = !halted_q &&
                   (((state_q == ST_FETCH) && !bus.imem_ready) ||
                    ((state_q == ST_MEM)   && !bus.dmem_ready));

  wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    if (!halted_q) begin
      case (state_q)
        ST_FETCH: begin
          if (bus.imem_ready) begin
            state_d = ST_DECODE;
          end else if (expired) begin
            halted_d = 1'b1;
            fault_d  = 1'b1;
          end
        end
        ST_DECODE:  state_d = ST_REGREAD;
        ST_REGREAD: state_d = ST_EXECUTE;
        ST_EXECUTE: state_d = ST_BRANCH;
        ST_BRANCH: begin
          state_d = (bus.is_load || bus.is_store) ? ST_MEM : ST_WRITEBACK;
        end
        ST_MEM: begin
          if (bus.dmem_ready) begin
            state_d = ST_WRITEBACK;
          end else if (expired) begin
            halted_d = 1'b1;
            fault_d  = 1'b1;
          end
        end
        ST_WRITEBACK: state_d = ST_PC_UPDATE;
        ST_PC_UPDATE: begin
          // A misaligned taken target freezes here with the old pc preserved.
          if (bus.taken_branch && !is_word_aligned(bus.branch_target)) begin
            halted_d = 1'b1;
            fault_d  = 1'b1;
          end else begin
            pc_d     = bus.taken_branch ? bus.branch_target : pc_q + PC_INC;
            state_d  = ST_FETCH;
            halted_d = bus.halt_req;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Strobes are also gated by rst so nothing is requested while reset is held.
  assign strobe_en    = !halted_q && !rst;
  assign bus.imem_req = strobe_en && (state_q == ST_FETCH);
  assign bus.dmem_req = strobe_en && (state_q == ST_MEM);
  assign bus.rf_we    = strobe_en && (state_q == ST_WRITEBACK) && bus.has_rd && !bus.is_store;
  assign bus.state    = state_q;
  assign bus.pc       = pc_q;
  assign bus.halted   = halted_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table-driven checks of pc_sequencer
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          do_reset;
    bit          is_load;
    bit          is_store;
    bit          has_rd;
    bit          taken;
    bit          halt;
    logic [31:0] target;
    int          imem_wait;
    int          dmem_wait;
    logic [31:0] exp_pc;
    int          exp_cyc;
    int          exp_we;
    int          exp_mem;
    logic [31:0] exp_trace;
    bit          exp_halted;
    bit          exp_fault;
    logic [2:0]  exp_fstate;
  } vec_t;

  vec_t tbl[10];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_ready    = 1'b0;
    bus.dmem_ready    = 1'b0;
    bus.is_load       = 1'b0;
    bus.is_store      = 1'b0;
    bus.has_rd        = 1'b0;
    bus.taken_branch  = 1'b0;
    bus.branch_target = 32'h0;
    bus.halt_req      = 1'b0;
  endtask

  // Entered and left at a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    rst = 1'b0;
    #1;
    check("imem_req_after_rst", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic run_instr(input vec_t v, output int cyc, output int we,
                           output int mem, output logic [31:0] tr);
    int         fc;
    int         mc;
    logic [2:0] st;
    bit         done;
    bus.is_load       = v.is_load;
    bus.is_store      = v.is_store;
    bus.has_rd        = v.has_rd;
    bus.taken_branch  = v.taken;
    bus.branch_target = v.target;
    bus.halt_req      = v.halt;
    cyc = 0; we = 0; mem = 0; tr = '1; fc = 0; mc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      st  = bus.state;
      cyc++;
      tr  = {tr[27:0], 1'b0, st};
      if (bus.rf_we) we++;
      if (bus.dmem_req) mem++;
      bus.imem_ready = (st == 3'd0) && (fc == v.imem_wait);
      bus.dmem_ready = (st == 3'd5) && (mc == v.dmem_wait);
      if (st == 3'd0) fc++;
      if (st == 3'd5) mc++;
      @(posedge clk);
      #1;
      done = ((bus.state == 3'd0) && (st == 3'd7)) || bus.halted;
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.halt_req   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc, we, mem, we_seen;
    logic [31:0] tr;
    bit          found;

    //           rst ld st rd tk ht target        iw  dw  exp_pc        cyc we mem trace         h  f  fstate
    tbl[0] = '{1, 0, 0, 1, 0, 0, 32'h0,         0,  0,  32'h4,        7,  1, 0, 32'hF0123467, 0, 0, 3'd0};
    tbl[1] = '{0, 1, 0, 1, 0, 0, 32'h0,         0,  3,  32'h8,        11, 1, 4, 32'h34555567, 0, 0, 3'd0};
    tbl[2] = '{0, 0, 1, 1, 0, 0, 32'h0,         0,  0,  32'hC,        8,  0, 1, 32'h01234567, 0, 0, 3'd0};
    tbl[3] = '{0, 0, 0, 0, 1, 0, 32'h100,       2,  0,  32'h100,      9,  0, 0, 32'h00123467, 0, 0, 3'd0};
    tbl[4] = '{0, 0, 0, 0, 1, 0, 32'hFFFFFFFC,  0,  0,  32'hFFFFFFFC, 7,  0, 0, 32'hF0123467, 0, 0, 3'd0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 32'h0,         0,  0,  32'h0,        7,  0, 0, 32'hF0123467, 0, 0, 3'd0};
    tbl[6] = '{0, 0, 0, 1, 0, 0, 32'h0,         15, 0,  32'h4,        22, 1, 0, 32'h00123467, 0, 0, 3'd0};
    tbl[7] = '{0, 0, 0, 0, 1, 0, 32'h102,       0,  0,  32'h4,        7,  0, 0, 32'hF0123467, 1, 1, 3'd7};
    tbl[8] = '{1, 0, 0, 0, 0, 0, 32'h0,         255,0,  32'h0,        16, 0, 0, 32'h00000000, 1, 1, 3'd0};
    tbl[9] = '{1, 0, 0, 1, 0, 1, 32'h0,         0,  0,  32'h4,        7,  1, 0, 32'hF0123467, 1, 0, 3'd0};

    clear_inputs();
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].do_reset) do_reset();
      run_instr(tbl[i], cyc, we, mem, tr);
      check($sformatf("v%0d_pc", i), bus.pc, tbl[i].exp_pc);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
      check($sformatf("v%0d_rf_we", i), 32'(we), 32'(tbl[i].exp_we));
      check($sformatf("v%0d_dmem_cycles", i), 32'(mem), 32'(tbl[i].exp_mem));
      check($sformatf("v%0d_trace", i), tr, tbl[i].exp_trace);
      check($sformatf("v%0d_halted", i), 32'(bus.halted), 32'(tbl[i].exp_halted));
      check($sformatf("v%0d_fault", i), 32'(bus.fault), 32'(tbl[i].exp_fault));
      if (tbl[i].exp_halted) begin
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        bus.has_rd     = 1'b1;
        for (int k = 0; k < 4; k++) begin
          check($sformatf("v%0d_frz_state", i), 32'(bus.state), 32'(tbl[i].exp_fstate));
          check($sformatf("v%0d_frz_pc", i), bus.pc, tbl[i].exp_pc);
          check($sformatf("v%0d_frz_strobes", i),
                32'({bus.imem_req, bus.dmem_req, bus.rf_we}), 32'd0);
          check($sformatf("v%0d_frz_halted", i), 32'(bus.halted), 32'd1);
          @(negedge clk);
        end
        clear_inputs();
      end
    end

    // Reset while a load waits in MEM: no writeback, pc back to RESET_PC.
    do_reset();
    run_instr(tbl[0], cyc, we, mem, tr);
    check("pre_abort_pc", bus.pc, 32'h4);
    bus.is_load = 1'b1;
    bus.has_rd  = 1'b1;
    we_seen = 0;
    found   = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.state == 3'd5) begin
        found = 1'b1;
      end else begin
        bus.imem_ready = (bus.state == 3'd0);
        if (bus.rf_we) we_seen++;
        @(negedge clk);
      end
    end
    check("abort_reach_mem", 32'(found), 32'd1);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    check("abort_mem_state", 32'(bus.state), 32'd5);
    check("abort_dmem_req", 32'(bus.dmem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    if (bus.rf_we) we_seen++;
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_pc", bus.pc, 32'h0);
    check("abort_dmem_req_off", 32'(bus.dmem_req), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.rf_we) we_seen++;
    end
    check("abort_no_rf_we", 32'(we_seen), 32'd0);
    check("abort_pc_held", bus.pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
